// File: rtl/pio_poll_pkg.sv
// Shared poller types: FSM state, slave register addresses and the per-state bus/stream decode.
package pio_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAP_ADDR,
        CAP_DATA,
        CLEAR,
        LVL_ADDR,
        LVL_DATA,
        EMIT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef struct packed {
        logic [1:0] addr;
        logic       cs;
        logic       write_n;
        logic       busy;
        logic       vld;
    } ctl_t;

    // Registered control outputs for the state being entered.
    function automatic ctl_t ctl_of(state_t s);
        ctl_t c;
        c.addr    = ADDR_DATA;
        c.cs      = 1'b0;
        c.write_n = 1'b1;
        c.busy    = (s != IDLE);
        c.vld     = 1'b0;
        case (s)
            CAP_ADDR, CAP_DATA: begin
                c.addr = ADDR_EDGE;
                c.cs   = 1'b1;
            end
            CLEAR: begin
                c.addr    = ADDR_EDGE;
                c.cs      = 1'b1;
                c.write_n = 1'b0;
            end
            LVL_ADDR, LVL_DATA: c.cs = 1'b1;
            EMIT:               c.vld = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pio_poll_timer.sv
// Poll interval down-counter (runs only while allowed, reloads on expiry or when held) and
// free-running 32-bit timestamp; expired is combinational from the registered count.
module pio_poll_timer #(
    parameter int unsigned POLL_INTERVAL = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        expired,
    output logic [31:0] timestamp
);

    localparam logic [23:0] RELOAD = 24'(POLL_INTERVAL - 1);

    logic [23:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= RELOAD;
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 32'd1;
            if (!run || count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - 24'd1;
            end
        end
    end

    assign expired = run && (count == '0);

endmodule

// File: rtl/pio_edge_poller.sv
// Avalon-MM poller of the edge-capture PIO: read capture, clear, read level, emit timestamped event.
// Expiry to ev_valid is 6 cycles; ev_ready low stalls in EMIT with the bus idle.
module pio_edge_poller
    import pio_poll_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int          DATA_W        = 32,
    parameter logic [15:0] SEQ_START     = 16'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [DATA_W-1:0] ev_mask,
    output logic [DATA_W-1:0] ev_level,
    output logic [31:0]       ev_time,
    output logic [15:0]       ev_seq,
    output logic              busy
);

    state_t            state;
    ctl_t              ctl;
    logic              poll_run;
    logic              expired;
    logic [31:0]       timestamp;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] level_q;
    logic [31:0]       time_q;
    logic [15:0]       seq_q;

    assign poll_run = (state == IDLE) && enable;

    pio_poll_timer #(
        .POLL_INTERVAL(POLL_INTERVAL)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (poll_run),
        .expired  (expired),
        .timestamp(timestamp)
    );

    // ctl is always loaded together with state so bus strobes come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ctl     <= ctl_of(IDLE);
            mask_q  <= '0;
            level_q <= '0;
            time_q  <= '0;
            seq_q   <= SEQ_START;
        end else begin
            case (state)
                IDLE: begin
                    if (expired) begin
                        state <= CAP_ADDR;
                        ctl   <= ctl_of(CAP_ADDR);
                    end
                end
                CAP_ADDR: begin
                    state <= CAP_DATA;
                    ctl   <= ctl_of(CAP_DATA);
                end
                CAP_DATA: begin
                    mask_q <= m_readdata;
                    time_q <= timestamp;
                    if (m_readdata == '0) begin
                        state <= IDLE;
                        ctl   <= ctl_of(IDLE);
                    end else begin
                        state <= CLEAR;
                        ctl   <= ctl_of(CLEAR);
                    end
                end
                CLEAR: begin
                    state <= LVL_ADDR;
                    ctl   <= ctl_of(LVL_ADDR);
                end
                LVL_ADDR: begin
                    state <= LVL_DATA;
                    ctl   <= ctl_of(LVL_DATA);
                end
                LVL_DATA: begin
                    level_q <= m_readdata;
                    state   <= EMIT;
                    ctl     <= ctl_of(EMIT);
                end
                EMIT: begin
                    if (ctl.vld && ev_ready) begin
                        seq_q <= seq_q + 16'd1;
                        state <= IDLE;
                        ctl   <= ctl_of(IDLE);
                    end
                end
                default: begin
                    state <= IDLE;
                    ctl   <= ctl_of(IDLE);
                end
            endcase
        end
    end

    assign m_address    = ctl.addr;
    assign m_chipselect = ctl.cs;
    assign m_write_n    = ctl.write_n;
    assign m_writedata  = '0;
    assign ev_valid     = ctl.vld;
    assign busy         = ctl.busy;
    assign ev_mask      = mask_q;
    assign ev_level     = level_q;
    assign ev_time      = time_q;
    assign ev_seq       = seq_q;

endmodule

// File: tb/tb_pio_edge_poller.sv
// Bench for pio_edge_poller: edge-capture slave model, bus monitor and event scoreboard.
module tb_pio_edge_poller;

    localparam int unsigned P    = 16;
    localparam logic [15:0] SEQ0 = 16'hFFFC;
    localparam int          TMO  = 4 * P + 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ev_ready = 1'b0;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        ev_valid;
    logic [31:0] ev_mask;
    logic [31:0] ev_level;
    logic [31:0] ev_time;
    logic [15:0] ev_seq;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pio_edge_poller #(
        .POLL_INTERVAL(P),
        .DATA_W       (32),
        .SEQ_START    (SEQ0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write_n   (m_write_n),
        .m_writedata (m_writedata),
        .m_readdata  (m_readdata),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_mask     (ev_mask),
        .ev_level    (ev_level),
        .ev_time     (ev_time),
        .ev_seq      (ev_seq),
        .busy        (busy)
    );

    // Slave: any-edge capture with clear-all write, readdata registered (latency 1).
    logic [31:0] pin = '0;
    logic [31:0] pin_q = '0;
    logic [31:0] cap = '0;
    always @(posedge clk) begin
        pin_q <= pin;
        if (m_chipselect && !m_write_n && m_address == 2'd3) cap <= '0;
        else cap <= cap | (pin ^ pin_q);
        if (m_chipselect && m_write_n) m_readdata <= (m_address == 2'd3) ? cap : pin;
    end

    logic [31:0] tb_ts = '0;
    always @(posedge clk) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;

    // Bus monitor: poll starts, capture-sample time, write strobes.
    wire cap_rd = m_chipselect && m_write_n && (m_address == 2'd3);
    logic        prev_cap = 1'b0;
    int          n_starts = 0;
    int          n_wr = 0;
    int          n_wr_bad = 0;
    logic [31:0] last_start = '0;
    logic [31:0] prev_start = '0;
    logic [31:0] cap_time = '0;
    always @(negedge clk) begin
        prev_cap <= cap_rd;
        if (cap_rd && !prev_cap) begin
            n_starts   <= n_starts + 1;
            prev_start <= last_start;
            last_start <= tb_ts;
        end
        if (cap_rd && prev_cap) cap_time <= tb_ts;
        if (m_chipselect && !m_write_n) begin
            n_wr <= n_wr + 1;
            if (m_address != 2'd3 || m_writedata != 32'd0) n_wr_bad <= n_wr_bad + 1;
        end
    end

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] level;
    } ev_t;
    ev_t         sb[$];
    logic [15:0] exp_seq = SEQ0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [31:0] toggles);
        pin = pin ^ toggles;
        tick();
        sb.push_back('{mask: toggles, level: pin});
    endtask

    // Returns at the CAP_DATA cycle of the next poll.
    task automatic wait_poll(output bit ok);
        int s0;
        s0 = n_starts;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (n_starts != s0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (ev_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        enable = 1'b1;
        ev_ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy, ev_valid, m_chipselect, m_write_n, m_address} !== 6'b000100) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=000100",
                     {busy, ev_valid, m_chipselect, m_write_n, m_address});
        end
        total++;
        if (ev_mask !== 32'd0 || ev_level !== 32'd0 || ev_time !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h want=0/0/0", ev_mask, ev_level, ev_time);
        end
        total++;
        if (ev_seq !== SEQ0) begin
            bad++;
            $display("FAIL reset_seq got=%h want=%h", ev_seq, SEQ0);
        end
        total++;
        if (m_writedata !== 32'd0) begin
            bad++;
            $display("FAIL reset_wdata got=%h want=0", m_writedata);
        end
        reset = 1'b0;
        n = 0;
        while (m_chipselect !== 1'b1 && n < TMO) begin
            tick();
            n++;
        end
        total++;
        if (n != int'(P) || m_address !== 2'd3 || m_write_n !== 1'b1) begin
            bad++;
            $display("FAIL first_poll got=%0d cycles addr=%0d want=%0d cycles addr=3", n, m_address, P);
        end
    endtask

    task automatic test_empty_poll();
        int  s0;
        int  w0;
        int  n;
        bit  saw_vld;
        tick();
        s0 = n_starts;
        w0 = n_wr;
        n = 0;
        saw_vld = 1'b0;
        while (n_starts == s0 && n < TMO) begin
            tick();
            n++;
            saw_vld = saw_vld | ev_valid;
        end
        total++;
        if (n_starts == s0) begin
            bad++;
            $display("FAIL empty_timeout got=no poll want=poll within %0d", TMO);
        end
        total++;
        if (int'(last_start - prev_start) != int'(P) + 2) begin
            bad++;
            $display("FAIL empty_period got=%0d want=%0d", int'(last_start - prev_start), P + 2);
        end
        total++;
        if (n_wr != w0 || saw_vld) begin
            bad++;
            $display("FAIL empty_activity got=writes %0d valid %0d want=writes 0 valid 0", n_wr - w0, saw_vld);
        end
        repeat (2) tick();
    endtask

    task automatic test_single_event();
        bit  ok;
        int  w0;
        ev_t e;
        ev_ready = 1'b1;
        w0 = n_wr;
        pin = 32'h5;
        tick();
        pin = 32'h4;
        tick();
        sb.push_back('{mask: 32'h5, level: 32'h4});
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || ev_mask !== e.mask || ev_level !== e.level) begin
            bad++;
            $display("FAIL single_data got=%0d %h/%h want=1 %h/%h", ok, ev_mask, ev_level, e.mask, e.level);
        end
        total++;
        if (ev_seq !== exp_seq || ev_time !== cap_time) begin
            bad++;
            $display("FAIL single_seq_time got=%h/%0d want=%h/%0d", ev_seq, ev_time, exp_seq, cap_time);
        end
        total++;
        if (n_wr != w0 + 1 || n_wr_bad != 0) begin
            bad++;
            $display("FAIL single_write got=%0d writes (%0d bad) want=1 (0 bad)", n_wr - w0, n_wr_bad);
        end
        total++;
        if (int'(tb_ts - last_start) != 5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_latency got=%0d busy=%0d want=5 busy=1", int'(tb_ts - last_start), busy);
        end
        exp_seq = exp_seq + 16'd1;
        tick();
        total++;
        if (ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_accept got=%0d want=0", ev_valid);
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        ev_t         e;
        logic [31:0] t_exp;
        ev_ready = 1'b0;
        inject(32'h3);
        wait_valid(ok);
        e = sb.pop_front();
        t_exp = cap_time;
        total++;
        if (!ok || ev_mask !== e.mask || ev_level !== e.level || ev_seq !== exp_seq) begin
            bad++;
            $display("FAIL bp_first got=%0d %h/%h/%h want=1 %h/%h/%h",
                     ok, ev_mask, ev_level, ev_seq, e.mask, e.level, exp_seq);
        end
        for (int i = 0; i < 50; i++) begin
            if (i == 10 || i == 30 || i == 40) pin = pin ^ 32'h80;
            tick();
            total++;
            if (ev_valid !== 1'b1 || ev_mask !== e.mask || ev_level !== e.level ||
                ev_seq !== exp_seq || ev_time !== t_exp || m_chipselect !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle %0d got=%0d %h/%h/%h/%0d cs=%0d want=1 %h/%h/%h/%0d cs=0",
                         i, ev_valid, ev_mask, ev_level, ev_seq, ev_time, m_chipselect,
                         e.mask, e.level, exp_seq, t_exp);
            end
        end
        ev_ready = 1'b1;
        tick();
        exp_seq = exp_seq + 16'd1;
        total++;
        if (ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got=%0d want=0", ev_valid);
        end
        sb.push_back('{mask: 32'h80, level: pin});
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || ev_mask !== e.mask || ev_level !== e.level || ev_seq !== exp_seq) begin
            bad++;
            $display("FAIL bp_next got=%0d %h/%h/%h want=1 %h/%h/%h",
                     ok, ev_mask, ev_level, ev_seq, e.mask, e.level, exp_seq);
        end
        exp_seq = exp_seq + 16'd1;
        tick();
    endtask

    task automatic test_enable_drop();
        bit  ok;
        ev_t e;
        int  s0;
        bit  saw_busy;
        ev_ready = 1'b1;
        inject(32'h30);
        wait_poll(ok);
        enable = 1'b0;
        wait_valid(ok);
        e = sb.pop_front();
        total++;
        if (!ok || ev_mask !== e.mask || ev_level !== e.level || ev_seq !== exp_seq) begin
            bad++;
            $display("FAIL endrop_event got=%0d %h/%h/%h want=1 %h/%h/%h",
                     ok, ev_mask, ev_level, ev_seq, e.mask, e.level, exp_seq);
        end
        exp_seq = exp_seq + 16'd1;
        tick();
        s0 = n_starts;
        saw_busy = 1'b0;
        repeat (3 * P) begin
            tick();
            saw_busy = saw_busy | busy;
        end
        total++;
        if (n_starts != s0 || saw_busy) begin
            bad++;
            $display("FAIL endrop_idle got=%0d polls busy=%0d want=0 polls busy=0", n_starts - s0, saw_busy);
        end
        enable = 1'b1;
    endtask

    task automatic test_seq_wrap();
        logic [31:0] toggles[2];
        logic [15:0] want_seq[2];
        bit          ok;
        ev_t         e;
        toggles[0] = 32'h100;
        toggles[1] = 32'h600;
        want_seq[0] = 16'h0000;
        want_seq[1] = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            inject(toggles[k]);
            wait_valid(ok);
            e = sb.pop_front();
            total++;
            if (!ok || ev_seq !== want_seq[k] || ev_mask !== e.mask || ev_level !== e.level) begin
                bad++;
                $display("FAIL wrap_%0d got=%0d %h/%h/%h want=1 %h/%h/%h",
                         k, ok, ev_seq, ev_mask, ev_level, want_seq[k], e.mask, e.level);
            end
            exp_seq = exp_seq + 16'd1;
            tick();
        end
    endtask

    task automatic test_reset_in_clear();
        bit ok;
        ev_ready = 1'b1;
        inject(32'h1000);
        wait_poll(ok);
        tick();
        total++;
        if (!ok || m_write_n !== 1'b0 || m_chipselect !== 1'b1 || m_address !== 2'd3) begin
            bad++;
            $display("FAIL clr_strobe got=%0d wn=%0d cs=%0d a=%0d want=1 wn=0 cs=1 a=3",
                     ok, m_write_n, m_chipselect, m_address);
        end
        reset = 1'b1;
        tick();
        total++;
        if (m_write_n !== 1'b1 || m_chipselect !== 1'b0 || busy !== 1'b0 || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_reset got=wn%0d cs%0d busy%0d vld%0d want=wn1 cs0 busy0 vld0",
                     m_write_n, m_chipselect, busy, ev_valid);
        end
        total++;
        if (ev_seq !== SEQ0) begin
            bad++;
            $display("FAIL clr_reset_seq got=%h want=%h", ev_seq, SEQ0);
        end
        reset = 1'b0;
        sb.delete();
        tick();
    endtask

    initial begin
        test_reset();
        test_empty_poll();
        test_single_event();
        test_backpressure();
        test_enable_drop();
        test_seq_wrap();
        test_reset_in_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
